// File: rtl/regfile_sb_if.sv
// Port bundle for regfile_sb: operand reads and busy flags (decode),
// the writeback write port, and the issue reservation port.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] indata;
  logic            RegWrite;
  logic            rsv_en;
  logic [AW-1:0]   rsv_rd;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            ready;

  modport master (
    output rs1, rs2, rd, indata, RegWrite, rsv_en, rsv_rd,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, ready
  );

  modport slave (
    input  rs1, rs2, rd, indata, RegWrite, rsv_en, rsv_rd,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// ID/EX integer register file: 2R/1W, hardwired zero, write bypass,
// per-register busy scoreboard and a sequential post-reset clear of the array.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   clr_ptr;
  logic [NREGS-1:0] busy;
  logic [XLEN-1:0] regs [NREGS];
  logic            run;
  logic            wr_ok;
  logic            rsv_ok;
  logic            hit1;
  logic            hit2;

  // Index maps to a real register and is not the hardwired zero register.
  function automatic logic idx_live(input logic [AW-1:0] idx);
    logic in_range;
    in_range = ({1'b0, idx} < (AW+1)'(NREGS));
    return in_range && !(ZERO_REG && (idx == '0));
  endfunction

  assign run    = (state == RUN);
  assign wr_ok  = run && bus.RegWrite && idx_live(bus.rd);
  assign rsv_ok = run && bus.rsv_en && idx_live(bus.rsv_rd);
  assign hit1   = BYPASS && wr_ok && (bus.rd == bus.rs1);
  assign hit2   = BYPASS && wr_ok && (bus.rd == bus.rs2);

  // Next-state logic: the clear walk ends on the edge that zeroes the last entry.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR: begin
        if (clr_ptr == AW'(NREGS - 1)) next_state = RUN;
        else                           next_state = CLEAR;
      end
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  // State, clear pointer and busy scoreboard; a reservation overrides a same-cycle write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) begin
        clr_ptr <= (next_state == RUN) ? '0 : clr_ptr + AW'(1);
        busy    <= '0;
      end else begin
        if (wr_ok)  busy[bus.rd]     <= 1'b0;
        if (rsv_ok) busy[bus.rsv_rd] <= 1'b1;
      end
    end
  end

  // Storage array has no reset; it is zeroed by the CLEAR walk instead.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) regs[clr_ptr] <= '0;
    else if (wr_ok)     regs[bus.rd]  <= bus.indata;
  end

  assign bus.rs1_value = (!run || !idx_live(bus.rs1)) ? '0 :
                         hit1 ? bus.indata : regs[bus.rs1];
  assign bus.rs2_value = (!run || !idx_live(bus.rs2)) ? '0 :
                         hit2 ? bus.indata : regs[bus.rs2];
  assign bus.rs1_busy  = run && idx_live(bus.rs1) && !hit1 && busy[bus.rs1];
  assign bus.rs2_busy  = run && idx_live(bus.rs2) && !hit2 && busy[bus.rs2];
  assign bus.ready     = run;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: default, no-bypass and 24-entry instances.
module tb_regfile_sb;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] want;

  regfile_sb_if #(.XLEN(32), .NREGS(32)) b   ();
  regfile_sb_if #(.XLEN(32), .NREGS(32)) bn  ();
  regfile_sb_if #(.XLEN(32), .NREGS(24)) b24 ();

  regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .CLK(CLK), .RST(RST), .bus(b));
  regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .RST(RST), .bus(bn));
  regfile_sb #(.XLEN(32), .NREGS(24), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_24 (
    .CLK(CLK), .RST(RST), .bus(b24));

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                       input logic [4:0] wrd, input logic [31:0] din,
                       input logic rsv, input logic [4:0] rrd);
    b.rs1 = r1;   b.rs2 = r2;   b.RegWrite = we;   b.rd = wrd;   b.indata = din;
    b.rsv_en = rsv;   b.rsv_rd = rrd;
    bn.rs1 = r1;  bn.rs2 = r2;  bn.RegWrite = we;  bn.rd = wrd;  bn.indata = din;
    bn.rsv_en = rsv;  bn.rsv_rd = rrd;
    b24.rs1 = r1; b24.rs2 = r2; b24.RegWrite = we; b24.rd = wrd; b24.indata = din;
    b24.rsv_en = rsv; b24.rsv_rd = rrd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int edges;
    drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    RST = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    repeat (3) @(posedge CLK);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.ready} !== want) begin n_err++; $display("FAIL reset_ready: got %h want %h", b.ready, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL reset_rs1_value: got %h want %h", b.rs1_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs1_busy} !== want) begin n_err++; $display("FAIL reset_rs1_busy: got %h want %h", b.rs1_busy, want); end

    exp_q.push_back(32'd32);
    RST = 1'b0;
    edges = 0;
    while (b.ready !== 1'b1 && edges < 100) begin @(posedge CLK); edges++; #1; end
    want = exp_q.pop_front(); n_cmp++;
    if (edges !== int'(want)) begin n_err++; $display("FAIL init_ready_edges: got %0d want %0d", edges, want); end
    exp_q.push_back(32'h1);
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b24.ready} !== want) begin n_err++; $display("FAIL init_ready_24: got %h want %h", b24.ready, want); end

    drive(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    tick();
    drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL preload_r5: got %h want %h", b.rs1_value, want); end

    // Write held throughout the reset and the clear walk must be discarded.
    drive(5'd5, 5'd0, 1'b1, 5'd5, 32'h1, 1'b0, 5'd0);
    RST = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.ready} !== want) begin n_err++; $display("FAIL rst_ready_immediate: got %h want %h", b.ready, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL rst_rs1_immediate: got %h want %h", b.rs1_value, want); end
    tick();
    RST = 1'b0;
    exp_q.push_back(32'd32);
    edges = 0;
    while (b.ready !== 1'b1 && edges < 100) begin @(posedge CLK); edges++; #1; end
    want = exp_q.pop_front(); n_cmp++;
    if (edges !== int'(want)) begin n_err++; $display("FAIL clear_ready_edges: got %0d want %0d", edges, want); end
    drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL clear_r5_zero: got %h want %h", b.rs1_value, want); end
  endtask

  task automatic test_zero_reg();
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL zero_value_pre: got %h want %h", b.rs1_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs1_busy} !== want) begin n_err++; $display("FAIL zero_busy_pre: got %h want %h", b.rs1_busy, want); end
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL zero_value_post: got %h want %h", b.rs1_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs1_busy} !== want) begin n_err++; $display("FAIL zero_busy_post: got %h want %h", b.rs1_busy, want); end
  endtask

  task automatic test_bypass();
    drive(5'd0, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
    tick();
    drive(5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'hA5A5A5A5);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL bypass_rs1: got %h want %h", b.rs1_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs2_value !== want) begin n_err++; $display("FAIL bypass_rs2: got %h want %h", b.rs2_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (bn.rs1_value !== want) begin n_err++; $display("FAIL nobypass_rs1_old: got %h want %h", bn.rs1_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (bn.rs2_value !== want) begin n_err++; $display("FAIL nobypass_rs2_old: got %h want %h", bn.rs2_value, want); end
    tick();
    drive(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (bn.rs1_value !== want) begin n_err++; $display("FAIL nobypass_rs1_new: got %h want %h", bn.rs1_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL bypass_rs1_array: got %h want %h", b.rs1_value, want); end
  endtask

  task automatic test_scoreboard();
    // t: reserve r9; not forwarded in the same cycle
    drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs2_busy} !== want) begin n_err++; $display("FAIL sb_busy_t: got %h want %h", b.rs2_busy, want); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      exp_q.push_back(32'h1);
      #1;
      want = exp_q.pop_front(); n_cmp++;
      if ({31'h0, b.rs2_busy} !== want) begin n_err++; $display("FAIL sb_busy_t%0d: got %h want %h", c, b.rs2_busy, want); end
    end
    tick();
    drive(5'd0, 5'd9, 1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h00000099);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs2_busy} !== want) begin n_err++; $display("FAIL sb_busy_masked_t3: got %h want %h", b.rs2_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs2_value !== want) begin n_err++; $display("FAIL sb_value_t3: got %h want %h", b.rs2_value, want); end
    tick();
    drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h00000099);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs2_busy} !== want) begin n_err++; $display("FAIL sb_busy_t4: got %h want %h", b.rs2_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs2_value !== want) begin n_err++; $display("FAIL sb_value_t4: got %h want %h", b.rs2_value, want); end
    drive(5'd0, 5'd9, 1'b1, 5'd9, 32'h00000077, 1'b1, 5'd9);
    tick();
    drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h00000077);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs2_busy} !== want) begin n_err++; $display("FAIL sb_rsv_wins: got %h want %h", b.rs2_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs2_value !== want) begin n_err++; $display("FAIL sb_rsv_data: got %h want %h", b.rs2_value, want); end
  endtask

  task automatic test_mid_reset();
    int edges;
    drive(5'd0, 5'd0, 1'b1, 5'd3, 32'h00000033, 1'b1, 5'd3);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h00000033);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs1_busy} !== want) begin n_err++; $display("FAIL mid_busy3_pre: got %h want %h", b.rs1_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs2_busy} !== want) begin n_err++; $display("FAIL mid_busy4_pre: got %h want %h", b.rs2_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b.rs1_value !== want) begin n_err++; $display("FAIL mid_r3_pre: got %h want %h", b.rs1_value, want); end
    @(negedge CLK);
    RST = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs1_busy} !== want) begin n_err++; $display("FAIL mid_busy3_rst: got %h want %h", b.rs1_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.rs2_busy} !== want) begin n_err++; $display("FAIL mid_busy4_rst: got %h want %h", b.rs2_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b.ready} !== want) begin n_err++; $display("FAIL mid_ready_rst: got %h want %h", b.ready, want); end
    #3;
    RST = 1'b0;
    exp_q.push_back(32'd32);
    edges = 0;
    while (b.ready !== 1'b1 && edges < 100) begin @(posedge CLK); edges++; #1; end
    want = exp_q.pop_front(); n_cmp++;
    if (edges !== int'(want)) begin n_err++; $display("FAIL mid_ready_edges: got %0d want %0d", edges, want); end
    for (int i = 0; i < 32; i++) begin
      b.rs1 = 5'(i);
      exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); n_cmp++;
      if (b.rs1_value !== want) begin n_err++; $display("FAIL mid_reclear_r%0d: got %h want %h", i, b.rs1_value, want); end
    end
  endtask

  task automatic test_npot();
    drive(5'd30, 5'd23, 1'b1, 5'd30, 32'hCAFEF00D, 1'b1, 5'd30);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (b24.rs1_value !== want) begin n_err++; $display("FAIL npot_r30_value_pre: got %h want %h", b24.rs1_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b24.rs1_busy} !== want) begin n_err++; $display("FAIL npot_r30_busy_pre: got %h want %h", b24.rs1_busy, want); end
    tick();
    drive(5'd23, 5'd30, 1'b1, 5'd23, 32'h00000023, 1'b0, 5'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h00000023);
    #1;
    want = exp_q.pop_front(); n_cmp++;
    if (b24.rs2_value !== want) begin n_err++; $display("FAIL npot_r30_value_post: got %h want %h", b24.rs2_value, want); end
    want = exp_q.pop_front(); n_cmp++;
    if ({31'h0, b24.rs2_busy} !== want) begin n_err++; $display("FAIL npot_r30_busy_post: got %h want %h", b24.rs2_busy, want); end
    want = exp_q.pop_front(); n_cmp++;
    if (b24.rs1_value !== want) begin n_err++; $display("FAIL npot_r23_bypass: got %h want %h", b24.rs1_value, want); end
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 24; i++) begin
      b24.rs1 = 5'(i);
      if (i == 23) exp_q.push_back(32'h00000023);
      else         exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); n_cmp++;
      if (b24.rs1_value !== want) begin n_err++; $display("FAIL npot_array_r%0d: got %h want %h", i, b24.rs1_value, want); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_mid_reset();
    test_npot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the ID/EX stage. It extends the basic two-read/one-write register file with several additions: a hardwired zero register, write-to-read bypass, a per-register busy scoreboard for in-flight producers, and a post-reset sequential clear of the storage array. The decode logic reads operands and busy flags from this block. Writeback drives the write port, and issue drives the reservation port.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (2..64); AW = $clog2(NREGS) is derived, not a parameter
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reservations
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- rs1  in  AW  read port 1 index
- rs2  in  AW  read port 2 index
- rd  in  AW  write index
- indata  in  XLEN  write data
- RegWrite  in  1  write enable
- rsv_en  in  1  reserve (mark busy) register rsv_rd
- rsv_rd  in  AW  reservation index
- rs1_value  out  XLEN  read data 1, combinational
- rs2_value  out  XLEN  read data 2, combinational
- rs1_busy  out  1  register rs1 has an outstanding producer
- rs2_busy  out  1  register rs2 has an outstanding producer
- ready  out  1  clear sequence complete; block accepts writes and reservations

## Operation
- State machine with two states, CLEAR and RUN. Internal state is a clear pointer clr_ptr (AW bits) and busy[NREGS].
- RST asserted, taking effect immediately:
  - state = CLEAR, clr_ptr = 0, all busy bits = 0, ready = 0.
  - Array contents are not reset asynchronously.
- CLEAR state:
  - Each posedge writes 0 to Registers[clr_ptr] and increments clr_ptr.
  - The edge that writes entry NREGS-1 moves the state to RUN.
  - RegWrite and rsv_en are ignored.
  - rsN_value = 0 and rsN_busy = 0 for both read ports.
- RUN state, on each posedge:
  - If RegWrite, the index is valid, and the write is not suppressed by the zero rule: Registers[rd] <= indata and busy[rd] <= 0.
  - If rsv_en, the index is valid, and the reservation is not suppressed by the zero rule: busy[rsv_rd] <= 1.
  - When the write and the reservation target the same register in one cycle, the reservation wins and busy ends at 1.
  - A write to a register that is not busy is legal and leaves its busy bit at 0.
- Read path, per port N, in priority order:
  1. ZERO_REG and rsN == 0 gives 0.
  2. Index >= NREGS gives 0.
  3. BYPASS, RegWrite, rd == rsN, and the write is not suppressed gives indata.
  4. Otherwise Registers[rsN].
- Busy path: rsN_busy = busy[rsN], forced to 0 in the following cases:
  - zero/invalid index;
  - CLEAR state;
  - a bypass hit on that port in the same cycle.
- Reservations are not forwarded: a register reserved in cycle t first shows busy in cycle t+1.
- Indices >= NREGS (only possible when NREGS is not a power of two): writes and reservations are dropped, and reads return 0 / not busy.
- RST asserted during RUN: the block returns to CLEAR, and every register is re-zeroed over NREGS cycles.

## Timing
- ready: 0 during reset. It rises after exactly NREGS posedges following RST deassertion.
- Read latency: 0 cycles, combinational from rsN, rd, RegWrite, and indata.
- Write latency: 1 edge. Data is visible through the array from the cycle after the write. With BYPASS=1 it is visible in the same cycle.
- Busy set latency: 1 edge after rsv_en. Busy clear latency: 1 edge after the matching RegWrite, or 0 cycles as seen on a port with a bypass hit.
- Reset values: rs1_value = rs2_value = 0, rs1_busy = rs2_busy = 0, ready = 0.
- Inputs must be stable around the CLK rising edge. RST may change at any time.

## Test plan
- Reset clear: preload register 5 = 0xDEADBEEF, pulse RST, hold RegWrite=1 with rd=5 and indata=0x1 throughout CLEAR → ready rises after exactly 32 edges, rs1=5 reads 0, and the write made during CLEAR is discarded.
- Zero register: RegWrite rd=0 indata=0xFFFFFFFF and rsv_en rsv_rd=0 → rs1=0 reads 0, rs1_busy=0, before and after the edge.
- Bypass: RegWrite rd=7 indata=0x12345678 with rs1=rs2=7 → both read 0x12345678 in the same cycle. Repeat with BYPASS=0 → the old value is read until the next cycle.
- Scoreboard: rsv_en rsv_rd=9 at t → rs2=9 busy at t+1. RegWrite rd=9 at t+3 → busy masked at t+3 and 0 from t+4. Simultaneous rsv_en and RegWrite on rd=9 → busy stays 1 and the data is updated.
- Mid-run reset: busy set on registers 3 and 4, assert RST for half a cycle → busy=0 and ready=0 immediately, and all registers read 0 after re-clear.
- Non-power-of-two: NREGS=24, write rd=30 → no array change, and rs1=30 reads 0 with not busy.
